// File: rtl/rvc_aligner_buf.sv
// Fetch aligner: buffers IFW-halfword fetch entries in a BUF_HW-deep halfword ring and
// emits one aligned RVI/RVC instruction per cycle, with prediction trimming and error early release.
module rvc_aligner_buf #(
  parameter int unsigned IFW    = 2,
  parameter int unsigned BUF_HW = 4
) (
  input  logic                                       s_clk_i,
  input  logic                                       s_resetn_i,
  input  logic                                       s_flush_i,
  input  logic                                       s_valid_i,
  output logic                                       s_ready_o,
  input  logic [16*IFW-1:0]                          s_data_i,
  input  logic [((IFW > 1) ? $clog2(IFW) : 1)-1:0]   s_start_i,
  input  logic [2:0]                                 s_ferr_i,
  input  logic [IFW-1:0]                             s_pred_i,
  output logic                                       s_valid_o,
  input  logic                                       s_ready_i,
  output logic [31:0]                                s_instr_o,
  output logic                                       s_rvc_o,
  output logic [2:0]                                 s_ferr_o,
  output logic                                       s_pred_o,
  output logic                                       s_aerr_o,
  output logic [$clog2(BUF_HW+1)-1:0]                s_occ_o
);

  localparam int unsigned SW = (IFW > 1) ? $clog2(IFW) : 1;
  localparam int unsigned OW = $clog2(BUF_HW + 1);
  localparam int unsigned PW = (BUF_HW > 1) ? $clog2(BUF_HW) : 1;

  if (BUF_HW < IFW + 1) begin : g_bad_depth
    $error("rvc_aligner_buf: BUF_HW must be at least IFW+1");
  end

  logic [15:0]   hw_q   [BUF_HW];
  logic [2:0]    ferr_q [BUF_HW];
  logic          pred_q [BUF_HW];
  logic [PW-1:0] rd_q, wr_q;
  logic [OW-1:0] occ_q;

  int unsigned   occ_u, st, n_in, pop_n, push_n;
  logic          found, rvc, valid, push;
  logic [PW-1:0] h1_idx;

  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int unsigned a);
    int unsigned s;
    s = 32'(p) + a;
    if (s >= BUF_HW) s = s - BUF_HW;
    return PW'(s);
  endfunction

  // Push count: entry starts at the (clamped) start index and stops after the first predicted halfword.
  always_comb begin
    st    = 32'(s_start_i);
    if (st >= IFW) st = IFW - 1;
    n_in  = IFW - st;
    found = 1'b0;
    for (int unsigned k = 0; k < IFW; k++) begin
      if (!found && k >= st && s_pred_i[k]) begin
        n_in  = k + 1 - st;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    occ_u  = 32'(occ_q);
    h1_idx = wrap(rd_q, 1);
    rvc    = hw_q[rd_q][1:0] != 2'b11;
    valid  = ~s_flush_i & ((occ_u >= 1 && rvc) || occ_u >= 2 ||
                           (occ_u == 1 && ferr_q[rd_q] != '0));
    // A valid head with occ==1 is either an RVC or an error early release: both pop one halfword.
    pop_n  = 0;
    if (valid && s_ready_i) pop_n = (rvc || occ_u == 1) ? 1 : 2;
    s_ready_o = s_flush_i | ((BUF_HW - occ_u + pop_n) >= IFW);
    push   = s_valid_i & s_ready_o & ~s_flush_i;
    push_n = push ? n_in : 0;
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      occ_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      for (int unsigned i = 0; i < BUF_HW; i++) begin
        hw_q[i]   <= '0;
        ferr_q[i] <= '0;
        pred_q[i] <= 1'b0;
      end
    end else if (s_flush_i) begin
      occ_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
    end else begin
      occ_q <= OW'(occ_u - pop_n + push_n);
      rd_q  <= wrap(rd_q, pop_n);
      wr_q  <= wrap(wr_q, push_n);
      for (int unsigned i = 0; i < IFW; i++) begin
        if (i < push_n) begin
          hw_q[wrap(wr_q, i)]   <= s_data_i[16*(st+i) +: 16];
          ferr_q[wrap(wr_q, i)] <= s_ferr_i;
          pred_q[wrap(wr_q, i)] <= s_pred_i[st+i];
        end
      end
    end
  end

  // Slots reset to zero decode as RVC, so the rvc flag is qualified by a non-empty buffer.
  always_comb begin
    s_valid_o = valid;
    s_instr_o = {(occ_u >= 2) ? hw_q[h1_idx] : 16'h0000, hw_q[rd_q]};
    s_rvc_o   = (occ_u != 0) & rvc;
    s_ferr_o  = (ferr_q[rd_q] != '0) ? ferr_q[rd_q] : (rvc ? 3'b000 : ferr_q[h1_idx]);
    s_pred_o  = rvc ? pred_q[rd_q] : pred_q[h1_idx];
    s_aerr_o  = valid & ~rvc & pred_q[rd_q];
    s_occ_o   = occ_q;
  end

endmodule

// File: tb/tb_rvc_aligner_buf.sv
// Directed bench for rvc_aligner_buf: per-cycle vector table on an IFW=2/BUF_HW=4 instance,
// plus hand sequences for IFW=4 trimming/start and asynchronous reset.
module tb_rvc_aligner_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // IFW=2, BUF_HW=4 instance
  logic        fl2, vi2, ro2, ri2, vo2, rvc2, pro2, ae2;
  logic [31:0] d2, ins2;
  logic [0:0]  st2;
  logic [2:0]  fe2, feo2, occ2;
  logic [1:0]  pr2;

  // IFW=4, BUF_HW=8 instance
  logic        fl4, vi4, ro4, ri4, vo4, rvc4, pro4, ae4;
  logic [63:0] d4;
  logic [31:0] ins4;
  logic [1:0]  st4;
  logic [2:0]  fe4, feo4;
  logic [3:0]  pr4, occ4;

  rvc_aligner_buf #(.IFW(2), .BUF_HW(4)) u_dut2 (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_flush_i(fl2), .s_valid_i(vi2), .s_ready_o(ro2),
    .s_data_i(d2), .s_start_i(st2), .s_ferr_i(fe2), .s_pred_i(pr2), .s_valid_o(vo2),
    .s_ready_i(ri2), .s_instr_o(ins2), .s_rvc_o(rvc2), .s_ferr_o(feo2), .s_pred_o(pro2),
    .s_aerr_o(ae2), .s_occ_o(occ2)
  );

  rvc_aligner_buf #(.IFW(4), .BUF_HW(8)) u_dut4 (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_flush_i(fl4), .s_valid_i(vi4), .s_ready_o(ro4),
    .s_data_i(d4), .s_start_i(st4), .s_ferr_i(fe4), .s_pred_i(pr4), .s_valid_o(vo4),
    .s_ready_i(ri4), .s_instr_o(ins4), .s_rvc_o(rvc4), .s_ferr_o(feo4), .s_pred_o(pro4),
    .s_aerr_o(ae4), .s_occ_o(occ4)
  );

  typedef struct {
    logic        vi; logic [31:0] d; logic st; logic [2:0] fe; logic [1:0] pr; logic ri; logic fl;
    logic        vo; logic ro; logic [31:0] ins; logic rvc; logic [2:0] feo; logic pro; logic ae;
    logic [2:0]  occ;
  } vec_t;

  localparam int NV = 31;
  vec_t tbl [NV];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        vi d             st fe      pr     ri fl  vo ro ins            rvc feo     pro ae occ
    tbl[0]  = '{1, 32'h00130013, 0, 3'd0, 2'b00, 1, 0, 0, 1, 32'h0,        0, 3'd0, 0, 0, 3'd0};
    tbl[1]  = '{1, 32'h00014501, 0, 3'd0, 2'b00, 1, 0, 1, 1, 32'h00130013, 0, 3'd0, 0, 0, 3'd2};
    tbl[2]  = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 1, 1, 32'h00014501, 1, 3'd0, 0, 0, 3'd2};
    tbl[3]  = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 1, 1, 32'h00000001, 1, 3'd0, 0, 0, 3'd1};
    tbl[4]  = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 0, 1, 32'h0,        0, 3'd0, 0, 0, 3'd0};
    tbl[5]  = '{1, 32'h0013BEEF, 1, 3'd0, 2'b00, 1, 0, 0, 1, 32'h0,        0, 3'd0, 0, 0, 3'd0};
    tbl[6]  = '{1, 32'h12340093, 0, 3'd0, 2'b00, 1, 0, 0, 1, 32'h0,        0, 3'd0, 0, 0, 3'd1};
    tbl[7]  = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 1, 1, 32'h00930013, 0, 3'd0, 0, 0, 3'd3};
    tbl[8]  = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 1, 1, 32'h00001234, 1, 3'd0, 0, 0, 3'd1};
    tbl[9]  = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 0, 1, 32'h0,        0, 3'd0, 0, 0, 3'd0};
    tbl[10] = '{1, 32'h22011101, 0, 3'd0, 2'b00, 0, 0, 0, 1, 32'h0,        0, 3'd0, 0, 0, 3'd0};
    tbl[11] = '{1, 32'h44013301, 0, 3'd0, 2'b00, 0, 0, 1, 1, 32'h22011101, 1, 3'd0, 0, 0, 3'd2};
    tbl[12] = '{1, 32'h66015501, 0, 3'd0, 2'b00, 0, 0, 1, 0, 32'h22011101, 1, 3'd0, 0, 0, 3'd4};
    tbl[13] = '{1, 32'h66015501, 0, 3'd0, 2'b00, 1, 0, 1, 0, 32'h22011101, 1, 3'd0, 0, 0, 3'd4};
    tbl[14] = '{1, 32'h66015501, 0, 3'd0, 2'b00, 1, 0, 1, 1, 32'h33012201, 1, 3'd0, 0, 0, 3'd3};
    tbl[15] = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 1, 0, 32'h44013301, 1, 3'd0, 0, 0, 3'd4};
    tbl[16] = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 1, 1, 32'h55014401, 1, 3'd0, 0, 0, 3'd3};
    tbl[17] = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 1, 1, 32'h66015501, 1, 3'd0, 0, 0, 3'd2};
    tbl[18] = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 1, 1, 32'h00006601, 1, 3'd0, 0, 0, 3'd1};
    tbl[19] = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 0, 1, 32'h0,        0, 3'd0, 0, 0, 3'd0};
    tbl[20] = '{1, 32'h0013AAAA, 1, 3'd2, 2'b00, 0, 0, 0, 1, 32'h0,        0, 3'd0, 0, 0, 3'd0};
    tbl[21] = '{0, 32'h0,        0, 3'd0, 2'b00, 0, 0, 1, 1, 32'h00000013, 0, 3'd2, 0, 0, 3'd1};
    tbl[22] = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 1, 1, 32'h00000013, 0, 3'd2, 0, 0, 3'd1};
    tbl[23] = '{1, 32'h0013AAAA, 1, 3'd2, 2'b10, 0, 0, 0, 1, 32'h0,        0, 3'd0, 0, 0, 3'd0};
    tbl[24] = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 1, 1, 32'h00000013, 0, 3'd2, 0, 1, 3'd1};
    tbl[25] = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 0, 1, 32'h0,        0, 3'd0, 0, 0, 3'd0};
    tbl[26] = '{1, 32'h22011101, 0, 3'd0, 2'b00, 1, 0, 0, 1, 32'h0,        0, 3'd0, 0, 0, 3'd0};
    tbl[27] = '{1, 32'h44013301, 0, 3'd0, 2'b00, 1, 1, 0, 1, 32'h0,        0, 3'd0, 0, 0, 3'd2};
    tbl[28] = '{0, 32'h0,        0, 3'd0, 2'b00, 1, 0, 0, 1, 32'h0,        0, 3'd0, 0, 0, 3'd0};
    tbl[29] = '{1, 32'h22011101, 0, 3'd0, 2'b00, 0, 0, 0, 1, 32'h0,        0, 3'd0, 0, 0, 3'd0};
    tbl[30] = '{0, 32'h0,        0, 3'd0, 2'b00, 0, 0, 1, 1, 32'h22011101, 1, 3'd0, 0, 0, 3'd2};

    {fl2, vi2, ri2, d2, st2, fe2, pr2} = '0;
    {fl4, vi4, ri4, d4, st4, fe4, pr4} = '0;
    ri4 = 1'b1;

    // Outputs held in reset
    #2;
    chk("rst_valid", 64'(vo2), 64'd0);
    chk("rst_ready", 64'(ro2), 64'd1);
    chk("rst_instr", 64'(ins2), 64'd0);
    chk("rst_rvc",   64'(rvc2), 64'd0);
    chk("rst_occ",   64'(occ2), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < NV; i++) begin
      vi2 = tbl[i].vi; d2 = tbl[i].d; st2 = tbl[i].st; fe2 = tbl[i].fe;
      pr2 = tbl[i].pr; ri2 = tbl[i].ri; fl2 = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 64'(vo2), 64'(tbl[i].vo));
      chk($sformatf("v%0d_ready", i), 64'(ro2), 64'(tbl[i].ro));
      chk($sformatf("v%0d_occ", i), 64'(occ2), 64'(tbl[i].occ));
      chk($sformatf("v%0d_aerr", i), 64'(ae2), 64'(tbl[i].ae));
      if (tbl[i].vo) begin
        chk($sformatf("v%0d_instr", i), 64'(ins2), 64'(tbl[i].ins));
        chk($sformatf("v%0d_rvc", i), 64'(rvc2), 64'(tbl[i].rvc));
        chk($sformatf("v%0d_ferr", i), 64'(feo2), 64'(tbl[i].feo));
        chk($sformatf("v%0d_pred", i), 64'(pro2), 64'(tbl[i].pro));
      end
      next_cycle();
    end
    vi2 = 1'b0; ri2 = 1'b0; fl2 = 1'b0;

    // IFW=4: prediction on halfword 1 drops halfwords 2 and 3
    vi4 = 1'b1; d4 = 64'h4681_4601_4581_4501; st4 = 2'd0; pr4 = 4'b0010;
    @(negedge clk);
    chk("w4_a_valid", 64'(vo4), 64'd0);
    chk("w4_a_ready", 64'(ro4), 64'd1);
    next_cycle();
    vi4 = 1'b0; pr4 = 4'b0000;
    @(negedge clk);
    chk("w4_b_valid", 64'(vo4), 64'd1);
    chk("w4_b_instr", 64'(ins4), 64'h45814501);
    chk("w4_b_pred",  64'(pro4), 64'd0);
    chk("w4_b_occ",   64'(occ4), 64'd2);
    next_cycle();
    @(negedge clk);
    chk("w4_c_valid", 64'(vo4), 64'd1);
    chk("w4_c_instr", 64'(ins4), 64'h00004581);
    chk("w4_c_pred",  64'(pro4), 64'd1);
    chk("w4_c_occ",   64'(occ4), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("w4_d_valid", 64'(vo4), 64'd0);
    chk("w4_d_occ",   64'(occ4), 64'd0);

    // IFW=4: unaligned start at halfword 2
    next_cycle();
    vi4 = 1'b1; st4 = 2'd2;
    next_cycle();
    vi4 = 1'b0; st4 = 2'd0;
    @(negedge clk);
    chk("w4_e_instr", 64'(ins4), 64'h46814601);
    chk("w4_e_occ",   64'(occ4), 64'd2);
    next_cycle();

    // Asynchronous reset mid-cycle while dut2 holds two halfwords
    @(negedge clk);
    chk("pre_rst_occ", 64'(occ2), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(vo2), 64'd0);
    chk("arst_ready", 64'(ro2), 64'd1);
    chk("arst_instr", 64'(ins2), 64'd0);
    chk("arst_rvc",   64'(rvc2), 64'd0);
    chk("arst_ferr",  64'(feo2), 64'd0);
    chk("arst_pred",  64'(pro2), 64'd0);
    chk("arst_aerr",  64'(ae2), 64'd0);
    chk("arst_occ",   64'(occ2), 64'd0);
    chk("arst_occ4",  64'(occ4), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    vi2 = 1'b1; d2 = 32'h00130013; ri2 = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(vo2), 64'd0);
    next_cycle();
    vi2 = 1'b0;
    @(negedge clk);
    chk("post_rst_instr", 64'(ins2), 64'h00130013);
    chk("post_rst_occ",   64'(occ2), 64'd2);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rvc_aligner_buf.md
Name: rvc_aligner_buf

Overview:
- Parametrised successor of the single-slot fetch aligner.
- Accepts IFW-halfword fetch entries from the IFB into a BUF_HW-deep halfword buffer. Emits one aligned RVI (32-bit) or RVC (16-bit) instruction per cycle to the decode stage over a valid/ready handshake.
- Supports wider fetch, entry into the middle of an entry (unaligned jump target), per-halfword prediction trimming, and fetch-error early release.
- Sits between the IFB and ID stage.

Parameters:
- IFW, 2, fetch entry width in 16-bit halfwords (2 or 4).
- BUF_HW, 4, buffer depth in halfwords. Must be >= IFW+1; elaboration error otherwise.

Ports:
- s_clk_i  in  1  clock
- s_resetn_i  in  1  asynchronous active-low reset
- s_flush_i  in  1  clear buffer; has priority over all other activity
- s_valid_i  in  1  IFB entry valid
- s_ready_o  out  1  aligner accepts the entry this cycle
- s_data_i  in  16*IFW  fetch entry; halfword k = bits [16k+15:16k]
- s_start_i  in  max(1,$clog2(IFW))  index of first useful halfword in the entry
- s_ferr_i  in  3  fetch error code of the entry; 0 = FETCH_VALID
- s_pred_i  in  IFW  bit k=1: predicted-taken instruction ends at halfword k
- s_valid_o  out  1  aligned instruction valid
- s_ready_i  in  1  decode consumes the instruction
- s_instr_o  out  32  aligned instruction
- s_rvc_o  out  1  output is a 16-bit instruction
- s_ferr_o  out  3  fetch error attached to the output instruction
- s_pred_o  out  1  prediction was performed from the output instruction
- s_aerr_o  out  1  alignment error (prediction on first half of an RVI)
- s_occ_o  out  $clog2(BUF_HW+1)  current halfword occupancy

Behaviour:
- Clock/reset: one clock, s_clk_i. Reset is asynchronous, active-low, s_resetn_i. On reset: occupancy 0, read/write pointers 0, all per-slot attributes 0. Outputs during reset: s_valid_o=0, s_ready_o=1, s_instr_o=0, s_rvc_o=0, s_ferr_o=0, s_pred_o=0, s_aerr_o=0, s_occ_o=0.
- Storage: circular buffer. Each slot holds halfword[15:0], ferr[2:0], pred. Pointers wrap modulo BUF_HW.
- Push count: n_in = IFW - s_start_i, reduced to (j+1-s_start_i), where j is the lowest k >= s_start_i with s_pred_i[k]=1. Halfwords after j are dropped.
- Acceptance: s_ready_o = (BUF_HW - occ + pop_this_cycle) >= IFW. The push happens when s_valid_i & s_ready_o & ~s_flush_i. The ready decision is all-or-nothing per entry, independent of trimming.
- Slot attributes on push: every written slot takes ferr = s_ferr_i; pred = s_pred_i[k] of its source halfword.
- Head decode: h0 = slot[rd], h1 = slot[rd+1]; rvc = h0[1:0] != 2'b11.
- s_valid_o (combinational) is high when any of the following holds, and never while s_flush_i=1:
  - occ >= 1 & rvc
  - occ >= 2
  - occ == 1 & h0.ferr != 0 (error early release; no wait for a second half that will not arrive)
- s_instr_o = {h1 if occ>=2 else 16'b0, h0}. s_rvc_o = rvc.
- s_ferr_o = h0.ferr if nonzero, else (rvc ? 0 : h1.ferr).
- s_pred_o = rvc ? h0.pred : h1.pred.
- s_aerr_o = s_valid_o & ~rvc & h0.pred.
- Pop: on s_valid_o & s_ready_i, occ decreases by 1 if rvc, or if error-early-release with occ==1; otherwise by 2.
- Simultaneous push and pop in the same cycle: occ_next = occ - pop + push.
- Flush: occ and pointers return to 0 next cycle. Input is not pushed and output is not popped in the flush cycle. s_ready_o stays high during flush.
- s_start_i values >= IFW: treated as IFW-1.
- Latency: an entry pushed in cycle t is visible at the output in cycle t+1. There is no bypass path.
- Throughput: one instruction per cycle when the IFB keeps pace.

Test Plan:
- IFW=2, entries 0x00130013 (RVI) then 0x00014501 (two RVC) -> out 0x00130013 rvc=0, then 0x4501 rvc=1, then 0x0001 rvc=1, on consecutive cycles.
- IFW=2, s_start_i=1, data {0x0013,0xXXXX}, then next entry {0x1234,0x0093} -> one RVI 0x00930013 assembled across entries, s_aerr_o=0.
- IFW=4, s_pred_i=4'b0010, halfwords 0x4501,0x4581,0x4601,0x4681 -> only 0x4501 and 0x4581 output (second with s_pred_o=1); 0x4601 and 0x4681 dropped; occ returns to 0.
- s_ready_i=0 held while IFB streams 2-halfword entries with BUF_HW=4 -> s_ready_o drops when occ > 2 and no halfword is lost. Releasing s_ready_i drains the buffer in order.
- Lone RVI first half 0x0013 with s_ferr_i=3'b010 and no following entry -> s_valid_o=1 with occ=1, s_ferr_o=3'b010, upper instruction bits 0. Pred on that halfword -> s_aerr_o=1.
- s_flush_i asserted during a simultaneous push and pop, then s_resetn_i pulsed low mid-stream -> next cycle occ=0 and s_valid_o=0. Reset drives all outputs to reset values asynchronously.
